uart_tx_arbiter: RTL

//   Shares the single UART transmitter between NREQ byte sources.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NREQ byte sources.
// Define UART_ARB_PKT_LOCK_EN to hold the grant from a packet's first byte to its req_last byte.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ack,
    output logic              uart_transmit,
    output logic [7:0]        uart_tx_byte,
    input  logic              uart_is_transmitting,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic              timeout_err
);

`ifdef UART_ARB_PKT_LOCK_EN
    typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE} state_t;
`endif

    state_t           state, state_d;
    logic [7:0]       cnt, cnt_d;
    logic [IDW-1:0]   ptr, ptr_d;
    logic [IDW-1:0]   winner, cand, load_id;
    logic             any_valid, load;
    logic             transmit_d, err_d;
    logic [NREQ-1:0]  ack_d;
    logic [7:0]       byte_d;
    logic [IDW-1:0]   gid_d;

`ifdef UART_ARB_PKT_LOCK_EN
    logic last_q, last_d;
`else
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    // Scan downward so the last hit is the requester closest after ptr.
    always_comb begin
        winner    = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        ptr_d      = ptr;
        transmit_d = 1'b0;
        err_d      = 1'b0;
        ack_d      = '0;
        byte_d     = uart_tx_byte;
        gid_d      = grant_id;
        load       = 1'b0;
        load_id    = winner;
`ifdef UART_ARB_PKT_LOCK_EN
        last_d     = last_q;
`endif
        unique case (state)
            IDLE: load = any_valid;
            WAIT_START: begin
                if (uart_is_transmitting) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) begin
`ifdef UART_ARB_PKT_LOCK_EN
                    state_d = last_q ? IDLE : HOLD;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef UART_ARB_PKT_LOCK_EN
            HOLD: begin
                load    = req_valid[grant_id];
                load_id = grant_id;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (load) begin
            transmit_d = 1'b1;
            ack_d      = NREQ'(1) << load_id;
            byte_d     = req_data[8*load_id +: 8];
            gid_d      = load_id;
            ptr_d      = load_id;
            cnt_d      = '0;
            state_d    = WAIT_START;
`ifdef UART_ARB_PKT_LOCK_EN
            last_d     = req_last[load_id];
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            ptr           <= IDW'(NREQ - 1);
            uart_transmit <= 1'b0;
            uart_tx_byte  <= '0;
            req_ack       <= '0;
            grant_id      <= '0;
            timeout_err   <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
            last_q        <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            ptr           <= ptr_d;
            uart_transmit <= transmit_d;
            uart_tx_byte  <= byte_d;
            req_ack       <= ack_d;
            grant_id      <= gid_d;
            timeout_err   <= err_d;
`ifdef UART_ARB_PKT_LOCK_EN
            last_q        <= last_d;
`endif
        end
    end

    assign busy = (state != IDLE);

endmodule
